// File: rtl/pipe_csa_addsub_if.sv
// Operand/result handshake bundle for pipe_csa_addsub.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipe_csa_addsub_if #(
    parameter int dataWidth = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [dataWidth-1:0] a;
    logic [dataWidth-1:0] b;
    logic                 sub;
    logic                 ci;
    logic                 out_valid;
    logic                 out_ready;
    logic [dataWidth-1:0] s;
    logic                 co;
    logic                 ovf;

    modport master (
        output in_valid, a, b, sub, ci, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, ci, out_ready,
        output in_ready, out_valid, s, co, ovf
    );
endinterface

// File: rtl/pipe_csa_addsub.sv
// Pipelined carry-select adder/subtractor: stage k resolves slice k from two
// precomputed sums, picked by the registered carry out of stage k-1.
module pipe_csa_addsub #(
    parameter int dataWidth = 32,
    parameter int nStage    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_csa_addsub_if.slave bus
);
    localparam int SW = dataWidth / nStage;

    if (nStage < 1) begin : g_bad_stage
        $error("pipe_csa_addsub: nStage must be at least 1");
    end else if ((dataWidth % nStage) != 0) begin : g_bad_width
        $error("pipe_csa_addsub: dataWidth must be a multiple of nStage");
    end

    // Both carry-in variants are formed in parallel so the late carry only drives a mux.
    function automatic logic [SW:0] slice_sel(input logic [SW-1:0] x,
                                              input logic [SW-1:0] y,
                                              input logic          cin);
        logic [SW:0] sum0;
        logic [SW:0] sum1;
        sum0 = {1'b0, x} + {1'b0, y};
        sum1 = {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, 1'b1};
        return cin ? sum1 : sum0;
    endfunction

    logic en_s;

    assign en_s         = !g_stage[nStage-1].vld_r || bus.out_ready;
    assign bus.in_ready = en_s;

    for (genvar k = 0; k < nStage; k++) begin : g_stage
        // Operand bits still unresolved when entering stage k, LSB-aligned.
        localparam int RW = dataWidth - k * SW;

        logic [RW-1:0]         a_s;
        logic [RW-1:0]         b_s;
        logic                  c_s;
        logic                  v_s;
        logic [SW:0]           sel_s;
        logic [(k+1)*SW-1:0]   res_nx_s;
        logic                  vld_r;
        logic                  cy_r;
        logic [(k+1)*SW-1:0]   res_r;

        if (k == 0) begin : g_src
            assign a_s      = bus.a;
            assign b_s      = bus.sub ? ~bus.b : bus.b;
            assign c_s      = bus.sub | bus.ci;
            assign v_s      = bus.in_valid;
            assign res_nx_s = sel_s[SW-1:0];
        end else begin : g_src
            assign a_s      = g_stage[k-1].g_ops.opa_r;
            assign b_s      = g_stage[k-1].g_ops.opb_r;
            assign c_s      = g_stage[k-1].cy_r;
            assign v_s      = g_stage[k-1].vld_r;
            assign res_nx_s = {sel_s[SW-1:0], g_stage[k-1].res_r};
        end

        assign sel_s = slice_sel(a_s[SW-1:0], b_s[SW-1:0], c_s);

        // Stage valid, carry and resolved low slices; all hold while en_s is low.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                cy_r  <= 1'b0;
                res_r <= '0;
            end else if (en_s) begin
                vld_r <= v_s;
                cy_r  <= sel_s[SW];
                res_r <= res_nx_s;
            end
        end

        if (k < nStage - 1) begin : g_ops
            logic [RW-SW-1:0] opa_r;
            logic [RW-SW-1:0] opb_r;

            // Upper operand slices travel along until their stage resolves them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    opa_r <= '0;
                    opb_r <= '0;
                end else if (en_s) begin
                    opa_r <= a_s[RW-1:SW];
                    opb_r <= b_s[RW-1:SW];
                end
            end
        end

        if (k == nStage - 1) begin : g_flag
            logic ovf_r;

            // Sign bits of a and post-inversion b are both visible in the top slice here.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (en_s) begin
                    ovf_r <= (a_s[RW-1] == b_s[RW-1]) && (sel_s[SW-1] != a_s[RW-1]);
                end
            end
        end
    end

    assign bus.out_valid = g_stage[nStage-1].vld_r;
    assign bus.s         = g_stage[nStage-1].res_r;
    assign bus.co        = g_stage[nStage-1].cy_r;
    assign bus.ovf       = g_stage[nStage-1].g_flag.ovf_r;
endmodule

// File: tb/tb_pipe_csa_addsub.sv
// Self-checking bench for pipe_csa_addsub: directed table on (32,4), streaming
// backpressure, reset mid-flight, and a sweep over (8,1), (16,2), (64,8).
module tb_pipe_csa_addsub;
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        sub;
    logic        ci;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_csa_addsub_if #(.dataWidth(8))  if8  ();
    pipe_csa_addsub_if #(.dataWidth(16)) if16 ();
    pipe_csa_addsub_if #(.dataWidth(32)) if32 ();
    pipe_csa_addsub_if #(.dataWidth(64)) if64 ();

    pipe_csa_addsub #(.dataWidth(8),  .nStage(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    pipe_csa_addsub #(.dataWidth(16), .nStage(2)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    pipe_csa_addsub #(.dataWidth(32), .nStage(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    pipe_csa_addsub #(.dataWidth(64), .nStage(8)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    assign if8.in_valid  = in_valid;  assign if8.a  = a[7:0];  assign if8.b  = b[7:0];
    assign if8.sub       = sub;       assign if8.ci = ci;      assign if8.out_ready  = out_ready;
    assign if16.in_valid = in_valid;  assign if16.a = a[15:0]; assign if16.b = b[15:0];
    assign if16.sub      = sub;       assign if16.ci = ci;     assign if16.out_ready = out_ready;
    assign if32.in_valid = in_valid;  assign if32.a = a[31:0]; assign if32.b = b[31:0];
    assign if32.sub      = sub;       assign if32.ci = ci;     assign if32.out_ready = out_ready;
    assign if64.in_valid = in_valid;  assign if64.a = a;       assign if64.b = b;
    assign if64.sub      = sub;       assign if64.ci = ci;     assign if64.out_ready = out_ready;

    logic        ov   [ND];
    logic        irdy [ND];
    logic        cov  [ND];
    logic        ovfv [ND];
    logic [63:0] sv   [ND];

    assign ov[0] = if8.out_valid;  assign irdy[0] = if8.in_ready;  assign cov[0] = if8.co;  assign ovfv[0] = if8.ovf;
    assign ov[1] = if16.out_valid; assign irdy[1] = if16.in_ready; assign cov[1] = if16.co; assign ovfv[1] = if16.ovf;
    assign ov[2] = if32.out_valid; assign irdy[2] = if32.in_ready; assign cov[2] = if32.co; assign ovfv[2] = if32.ovf;
    assign ov[3] = if64.out_valid; assign irdy[3] = if64.in_ready; assign cov[3] = if64.co; assign ovfv[3] = if64.ovf;
    assign sv[0] = {56'd0, if8.s};
    assign sv[1] = {48'd0, if16.s};
    assign sv[2] = {32'd0, if32.s};
    assign sv[3] = if64.s;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        ci;
        logic [63:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    function automatic int wid_of(int i);
        return 8 << i;
    endfunction

    function automatic int nst_of(int i);
        return 1 << i;
    endfunction

    function automatic res_t golden(int w, logic [63:0] x, logic [63:0] y, logic sb, logic c);
        logic [64:0] mask;
        logic [64:0] aa;
        logic [64:0] bb;
        logic [64:0] full;
        res_t        r;
        mask   = (65'd1 << w) - 65'd1;
        aa     = {1'b0, x} & mask;
        bb     = (sb ? ~{1'b0, y} : {1'b0, y}) & mask;
        full   = aa + bb + {64'd0, (sb | c)};
        r.s    = full[63:0] & mask[63:0];
        r.co   = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(string name, logic got, logic exp);
        chk(name, {63'd0, got}, {63'd0, exp});
    endtask

    // One isolated operation on all four instances; checks latency and result.
    task automatic run_one(string tag, logic [63:0] va, logic [63:0] vb, logic vs, logic vc,
                           logic [63:0] es, logic eco, logic eovf, logic use_tbl);
        res_t e;
        a = va; b = vb; sub = vs; ci = vc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk1({tag, " in_ready"}, irdy[2], 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < ND; i++) begin
                chk1($sformatf("%s w%0d valid c%0d", tag, wid_of(i), c), ov[i], (c == nst_of(i) - 1));
                if (c == nst_of(i) - 1) begin
                    e = golden(wid_of(i), va, vb, vs, vc);
                    if (i == 2 && use_tbl) begin
                        e.s = es; e.co = eco; e.ovf = eovf;
                    end
                    chk($sformatf("%s w%0d s", tag, wid_of(i)), sv[i], e.s);
                    chk1($sformatf("%s w%0d co", tag, wid_of(i)), cov[i], e.co);
                    chk1($sformatf("%s w%0d ovf", tag, wid_of(i)), ovfv[i], e.ovf);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // 16 random ops on the 32-bit instance with random out_ready and a 5-cycle stall.
    task automatic stream_test();
        res_t       q[$];
        res_t       e;
        logic [3:0] mv = 4'd0;
        logic       en;
        int         sent = 0;
        int         got  = 0;
        int         cyc  = 0;
        while ((sent < 16 || got < 16) && cyc < 300) begin
            in_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
            a         = {32'd0, $urandom()};
            b         = {32'd0, $urandom()};
            sub       = 1'($urandom_range(0, 1));
            ci        = 1'($urandom_range(0, 1));
            out_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : ($urandom_range(0, 2) != 0);
            #1;
            en = !mv[3] || out_ready;
            chk1($sformatf("bp in_ready c%0d", cyc), irdy[2], en);
            chk1($sformatf("bp out_valid c%0d", cyc), ov[2], mv[3]);
            if (mv[3]) begin
                if (q.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL bp model queue empty at c%0d", cyc);
                end else begin
                    e = q[0];
                    chk($sformatf("bp s c%0d", cyc), sv[2], e.s);
                    chk1($sformatf("bp co c%0d", cyc), cov[2], e.co);
                    chk1($sformatf("bp ovf c%0d", cyc), ovfv[2], e.ovf);
                    if (out_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && en) begin
                q.push_back(golden(32, a, b, sub, ci));
                sent++;
            end
            if (en) mv = {mv[2:0], in_valid};
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 300) begin
            checks++; errs++;
            $display("FAIL bp timeout: got %0d results expected 16", got);
        end
    endtask

    vec_t        tbl [11];
    logic [63:0] corner [4];
    logic [63:0] ra;
    logic [63:0] rb;

    initial begin
        tbl[0]  = '{64'hFFFFFFFF, 64'h1,        1'b0, 1'b0, 64'h00000000, 1'b1, 1'b0};
        tbl[1]  = '{64'h7FFFFFFF, 64'h1,        1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1};
        tbl[2]  = '{64'h7FFFFFFE, 64'h0,        1'b0, 1'b1, 64'h7FFFFFFF, 1'b0, 1'b0};
        tbl[3]  = '{64'h5,        64'h7,        1'b1, 1'b0, 64'hFFFFFFFE, 1'b0, 1'b0};
        tbl[4]  = '{64'h80000000, 64'h1,        1'b1, 1'b0, 64'h7FFFFFFF, 1'b1, 1'b1};
        tbl[5]  = '{64'h10,       64'h10,       1'b1, 1'b1, 64'h00000000, 1'b1, 1'b0};
        tbl[6]  = '{64'h00FF00FF, 64'h00010001, 1'b0, 1'b1, 64'h01000101, 1'b0, 1'b0};
        tbl[7]  = '{64'h12345678, 64'h87654321, 1'b0, 1'b0, 64'h99999999, 1'b0, 1'b0};
        tbl[8]  = '{64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b0, 64'h00000000, 1'b1, 1'b0};
        tbl[9]  = '{64'h0,        64'h80000000, 1'b1, 1'b0, 64'h80000000, 1'b0, 1'b1};
        tbl[10] = '{64'h80000000, 64'h80000000, 1'b0, 1'b0, 64'h00000000, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 64'd0; b = 64'd0; sub = 1'b0; ci = 1'b0;
        #2;
        for (int i = 0; i < ND; i++) begin
            chk1($sformatf("reset w%0d out_valid", wid_of(i)), ov[i], 1'b0);
            chk($sformatf("reset w%0d s", wid_of(i)), sv[i], 64'd0);
            chk1($sformatf("reset w%0d co", wid_of(i)), cov[i], 1'b0);
            chk1($sformatf("reset w%0d ovf", wid_of(i)), ovfv[i], 1'b0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < ND; i++) chk1($sformatf("reset w%0d in_ready", wid_of(i)), irdy[i], 1'b1);

        for (int i = 0; i < 11; i++)
            run_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].ci,
                    tbl[i].s, tbl[i].co, tbl[i].ovf, 1'b1);

        stream_test();

        // Three ops in flight, then reset before the first can emerge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 64'(32'h1000 + i); b = 64'd3; sub = 1'b0; ci = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk1("rst mid out_valid", ov[2], 1'b0);
        chk("rst mid s", sv[2], 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk1($sformatf("rst after out_valid c%0d", c), ov[2], 1'b0);
            @(posedge clk); #1;
        end
        run_one("post_rst", 64'h0000ABCD, 64'h00001234, 1'b0, 1'b1, 64'h0000BE02, 1'b0, 1'b0, 1'b1);

        for (int wi = 0; wi < ND; wi++) begin
            corner[0] = 64'd0;
            corner[1] = {64{1'b1}};
            corner[2] = 64'd1 << (wid_of(wi) - 1);
            corner[3] = corner[2] - 64'd1;
            for (int ai = 0; ai < 4; ai++)
                for (int bi = 0; bi < 4; bi++)
                    for (int sb = 0; sb < 2; sb++)
                        run_one($sformatf("sw%0d_%0d%0d%0d", wid_of(wi), ai, bi, sb),
                                corner[ai], corner[bi], sb[0], 1'b1, 64'd0, 1'b0, 1'b0, 1'b0);
        end
        for (int r = 0; r < 8; r++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            run_one($sformatf("rnd%0d", r), ra, rb, r[0], r[1], 64'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
